media_campioni: RTL



---
 rtl/media_campioni_pkg.sv | 15 +
 rtl/add.sv | 13 +
 rtl/media_campioni_acc_somma.sv | 35 +++
 rtl/media_campioni.sv | 106 ++++++++++
 4 files changed

// File: rtl/media_campioni_pkg.sv
// rtl/media_campioni_pkg.sv - shared state encodings and handshake levels for the batch-mean stage
package media_campioni_pkg;

  typedef enum logic [1:0] {
    IN_WAIT   = 2'd0,
    IN_ACK    = 2'd1,
    OUT_VALID = 2'd2,
    OUT_ACK   = 2'd3
  } star_t;

  // Both handshakes are active low: dav_ low means data valid, rfd low means taken.
  localparam logic VALID = 1'b0;
  localparam logic ACK   = 1'b0;

endpackage

// File: rtl/add.sv
// rtl/add.sv - N-bit adder with carry-in
module add #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s
);

  assign s = a + b + N'(c_in);

endmodule

// File: rtl/media_campioni_acc_somma.sv
// rtl/media_campioni_acc_somma.sv - W+LOG2K-bit accumulator with clear and enable
module acc_somma #(
  parameter int W     = 32,
  parameter int LOG2K = 2
) (
  input  logic                 clock,
  input  logic                 reset_,
  input  logic                 clr,
  input  logic                 en,
  input  logic [W-1:0]         d,
  output logic [W+LOG2K-1:0]   sum
);

  localparam int N = W + LOG2K;

  logic [N-1:0] d_ext;
  logic [N-1:0] sum_nx;

  // LOG2K guard bits absorb K full-scale samples without wrapping.
  assign d_ext = N'(d);

  add #(.N(N)) u_add (
    .a    (sum),
    .b    (d_ext),
    .c_in (1'b0),
    .s    (sum_nx)
  );

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_)  sum <= '0;
    else if (clr) sum <= '0;
    else if (en)  sum <= sum_nx;
  end

endmodule

// File: rtl/media_campioni.sv
// rtl/media_campioni.sv - accumulates 2^LOG2K samples over dav_/rfd and publishes their truncated mean
module media_campioni
  import media_campioni_pkg::*;
#(
  parameter int LOG2K = 2,
  parameter int W     = 32
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         dav_in_,
  output logic         rfd_in,
  input  logic [W-1:0] q_in,
  output logic         dav_out_,
  input  logic         rfd_out,
  output logic [W-1:0] m
);

  localparam int SW = W + LOG2K;
  localparam int CW = LOG2K + 1;
  localparam logic [CW-1:0] K_CNT = CW'(1 << LOG2K);

  star_t          star, star_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           rfd_in_nx, dav_out_nx;
  logic [W-1:0]   m_nx;
  logic           acc_en, acc_clr;
  logic [SW-1:0]  sum;
  logic [W-1:0]   mean;

  acc_somma #(.W(W), .LOG2K(LOG2K)) u_acc (
    .clock  (clock),
    .reset_ (reset_),
    .clr    (acc_clr),
    .en     (acc_en),
    .d      (q_in),
    .sum    (sum)
  );

  // Dividing by K is just dropping the low LOG2K bits.
  assign mean = sum[SW-1:LOG2K];

  always_comb begin
    star_nx    = star;
    cnt_nx     = cnt;
    rfd_in_nx  = rfd_in;
    dav_out_nx = dav_out_;
    m_nx       = m;
    acc_en     = 1'b0;
    acc_clr    = 1'b0;
    case (star)
      IN_WAIT: begin
        rfd_in_nx = ~ACK;
        if (dav_in_ == VALID) begin
          acc_en    = 1'b1;
          cnt_nx    = cnt + CW'(1);
          rfd_in_nx = ACK;
          star_nx   = IN_ACK;
        end
      end
      IN_ACK: begin
        if (dav_in_ != VALID) begin
          rfd_in_nx = ~ACK;
          if (cnt == K_CNT) begin
            m_nx       = mean;
            dav_out_nx = VALID;
            star_nx    = OUT_VALID;
          end else begin
            star_nx = IN_WAIT;
          end
        end
      end
      OUT_VALID: begin
        if (rfd_out == ACK) begin
          dav_out_nx = ~VALID;
          star_nx    = OUT_ACK;
        end
      end
      OUT_ACK: begin
        dav_out_nx = ~VALID;
        if (rfd_out != ACK) begin
          acc_clr = 1'b1;
          cnt_nx  = '0;
          star_nx = IN_WAIT;
        end
      end
      default: star_nx = IN_WAIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      star     <= IN_WAIT;
      cnt      <= '0;
      rfd_in   <= 1'b1;
      dav_out_ <= 1'b1;
      m        <= '0;
    end else begin
      star     <= star_nx;
      cnt      <= cnt_nx;
      rfd_in   <= rfd_in_nx;
      dav_out_ <= dav_out_nx;
      m        <= m_nx;
    end
  end

endmodule
